// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- iterative multiply/divide sequencer and HI/LO register file
// for the MIPS integer pipeline (EX stage, beside the main ALU).
//
// Runs MULT/MULTU (32-step shift-add) and DIV/DIVU (32-step restoring
// divide) on operand magnitudes, then applies a sign fix-up and commits
// the 64-bit result to HI/LO on the edge leaving DONE. Also services
// MTHI/MTLO and exposes HI/LO for MFHI/MFLO.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined     -> MULT/MULTU use the synthesis multiplier in one cycle
//                  (IDLE -> DONE, stall high for 2 cycles).
//   not defined -> multiply uses the 32-cycle iterative path.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   issue request, sampled only in IDLE
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    in   rs operand (multiplicand / dividend), also MTHI/MTLO data
//   src_b    in   rt operand (multiplier / divisor)
//   flush    in   abort the operation in flight, no HI/LO write
//   mthi_we  in   write src_a to HI (IDLE only)
//   mtlo_we  in   write src_a to LO (IDLE only)
//   stall    out  start | (state != IDLE), combinational
//   busy     out  state != IDLE, registered
//   done     out  one-cycle pulse in DONE
//   hi       out  HI register
//   lo       out  LO register

module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Latched operation context
    logic             op_div;    // 1: divide, 0: multiply
    logic             sign_q;    // negate product / quotient at fix-up
    logic             sign_r;    // negate remainder (sign of dividend)
    logic             div_zero;  // divide by zero: skip the HI/LO write
    logic [5:0]       cnt;
    logic [WIDTH-1:0] mag_b;     // multiplicand / divisor magnitude

    // Shared working register.
    //   multiply: {partial product high, multiplier bits not yet consumed}
    //   divide:   {partial remainder, dividend bits shifting into quotient}
    logic [W2-1:0]    acc;

    // ------------------------------------------------------------------
    // Operand magnitudes (raw for unsigned ops)
    // ------------------------------------------------------------------
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero;

    assign a_neg  = ~op[0] & src_a[WIDTH-1];
    assign b_neg  = ~op[0] & src_b[WIDTH-1];
    assign a_mag  = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag  = b_neg ? (~src_b + 1'b1) : src_b;
    assign b_zero = (src_b == '0);

`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{WIDTH{1'b0}}, a_mag};
    assign fast_b    = {{WIDTH{1'b0}}, b_mag};
    assign fast_prod = fast_a * fast_b;
`endif

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole 65-bit value right.
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_nx;

    assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and
    // try a subtract; a clear borrow bit means the quotient bit is 1.
    // The shifted remainder needs 33 bits since it may reach 2*divisor-1.
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ok;
    logic [W2-1:0]    div_nx;

    assign div_sh   = acc[W2-1:WIDTH-1];
    assign div_diff = div_sh - {1'b0, mag_b};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_nx   = div_ok ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                             : {div_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign fix-up applied in DONE
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [W2-1:0]    prod_fix;

    assign prod_fix = sign_q ? (~acc + 1'b1) : acc;

    always_comb begin
        res_hi = prod_fix[W2-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (op_div) begin
            // Most-negative / -1 wraps back to most-negative, no trap.
            res_lo = sign_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            res_hi = sign_r ? (~acc[W2-1:WIDTH] + 1'b1) : acc[W2-1:WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = start | (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (op[1] && b_zero)
                        state_nx = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op[1])
                        state_nx = DONE;
`endif
                    else
                        state_nx = CALC;
                end
            end
            CALC: begin
                if (flush)            state_nx = IDLE;
                else if (cnt == 6'd31) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
                done     = ~flush;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else     busy <= (state_nx != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            mag_b    <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_div   <= op[1];
                        sign_q   <= a_neg ^ b_neg;
                        sign_r   <= a_neg;
                        div_zero <= op[1] & b_zero;
                        cnt      <= '0;
                        mag_b    <= b_mag;
                        // Same seed for both loops: src_a magnitude in the
                        // low half is the multiplier / the dividend.
                        acc      <= {{WIDTH{1'b0}}, a_mag};
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) acc <= fast_prod;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    acc <= op_div ? div_nx : mul_nx;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // HI/LO register file
    // ------------------------------------------------------------------
    logic result_we;
    assign result_we = (state == DONE) & ~flush & ~div_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (result_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == IDLE && !flush) begin
            // A move issued alongside start lands now; the operation's
            // result overwrites it later.
            if (mthi_we) hi <= src_a;
            if (mtlo_we) lo <= src_a;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic vectors, latency, divide by
// zero, MTHI/MTLO, flush, async reset and back-to-back issue.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, mthi_we, mtlo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_DONE = 1;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_DONE = 33;
`endif

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Issue one op from IDLE and follow it until stall drops.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input int edone);
        int n, dat, dcnt;
        op = o; src_a = a; src_b = b; start = 1'b1; #1;
        n = 0; dat = -1; dcnt = 0;
        while (stall && n < 100) begin
            if (done) begin dat = n; dcnt++; end
            @(posedge clk); #1; start = 1'b0; #1;
            n++;
        end
        chk({tag, "_lat"},   n,    elat);
        chk({tag, "_doneat"}, dat, edone);
        chk({tag, "_dcnt"},  dcnt, 1);
        chk({tag, "_hi"},    hi,   eh);
        chk({tag, "_lo"},    lo,   el);
    endtask

    initial begin
        int n, dcnt;
        rst = 1'b1; start = 0; flush = 0; mthi_we = 0; mtlo_we = 0;
        op = 2'b00; src_a = 0; src_b = 0;
        #3;
        chk("rst_hi",    hi,    0);
        chk("rst_lo",    lo,    0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_stall", stall, 0);
        #9 rst = 1'b0;
        tick;

        run_op("mult_m2x3",  2'b00, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT, MUL_DONE);
        run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, MUL_LAT, MUL_DONE);
        run_op("mult_mixed", 2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, MUL_LAT, MUL_DONE);
        run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
        run_op("div_7_m2",   2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 34, 33);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33);
        run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 33);

        // MTHI / MTLO then divide by zero leaves them untouched
        tick;
        mthi_we = 1; src_a = 32'h1234; tick; mthi_we = 0;
        mtlo_we = 1; src_a = 32'h5678; tick; mtlo_we = 0;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        run_op("divu_zero", 2'b11, 32'h99, 32'h0, 32'h1234, 32'h5678, 2, 1);

        // flush together with start in IDLE: start ignored
        op = 2'b10; src_a = 32'd50; src_b = 32'd3; start = 1; flush = 1;
        tick; start = 0; flush = 0; #1;
        chk("flush_start_busy", busy, 0);

        // flush mid-CALC
        start = 1; tick; start = 0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin if (done) dcnt++; tick; end
        flush = 1; tick; flush = 0; #1;
        chk("flush_stall", stall, 0);
        chk("flush_busy",  busy,  0);
        for (int i = 0; i < 40; i++) begin if (done) dcnt++; tick; end
        chk("flush_nodone", dcnt, 0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h5678);

        // async reset mid-operation
        op = 2'b11; src_a = 32'd1000; src_b = 32'd9; start = 1; tick; start = 0;
        for (int i = 0; i < 5; i++) tick;
        #2 rst = 1; #1;
        chk("arst_hi",   hi,   0);
        chk("arst_lo",   lo,   0);
        chk("arst_busy", busy, 0);
        #1 rst = 0;
        tick;

        // MTLO with start, stray start + MTHI during CALC, then a new op
        op = 2'b11; src_a = 32'hAAAA; src_b = 32'h10; mtlo_we = 1; start = 1;
        tick; start = 0; mtlo_we = 0; #1;
        chk("b2b_mtlo", lo, 32'hAAAA);
        n = 1;
        for (int i = 0; i < 5; i++) begin tick; n++; end
        op = 2'b00; src_a = 32'hDEAD; src_b = 32'h7; start = 1; mthi_we = 1;
        tick; n++; start = 0; mthi_we = 0; #1;
        chk("b2b_mthi_busy", hi, 32'h0);
        while (stall && n < 100) begin tick; #1; n++; end
        chk("b2b_lat", n, 34);
        chk("b2b_lo",  lo, 32'hAAA);
        chk("b2b_hi",  hi, 32'hA);
        run_op("b2b_next", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15, MUL_LAT, MUL_DONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
